// File: rtl/multi_dataflow_stream_sched_if.sv
// Handshake bundle between the HWPE control slave, the streamers and the job scheduler.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface multi_dataflow_stream_sched_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = 32
);
  logic                     clear;
  logic                     start;
  logic [N_OUT*CNT_W-1:0]   cnt_limit;
  logic [N_IN-1:0]          in_ready;
  logic [N_OUT-1:0]         out_ready;
  logic [N_IN-1:0]          in_req;
  logic [N_OUT-1:0]         out_req;
  logic [N_IN-1:0]          in_done;
  logic [N_OUT-1:0]         out_done;
  logic [N_OUT-1:0]         out_beat;
  logic                     engine_clear;
  logic                     engine_en;
  logic                     busy;
  logic                     done;
  logic [N_OUT-1:0]         overrun;
  logic [31:0]              cycles;

  modport master (
    input  clear, start, cnt_limit, in_ready, out_ready, in_done, out_done, out_beat,
    output in_req, out_req, engine_clear, engine_en, busy, done, overrun, cycles
  );

  modport slave (
    output clear, start, cnt_limit, in_ready, out_ready, in_done, out_done, out_beat,
    input  in_req, out_req, engine_clear, engine_en, busy, done, overrun, cycles
  );
endinterface

// File: rtl/multi_dataflow_stream_sched.sv
// Job-level scheduler for multi-stream HWPE accelerators: arms every source and sink streamer,
// enables the engine, counts sink beats against programmed limits and reports completion.
module multi_dataflow_stream_sched #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = 32
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  multi_dataflow_stream_sched_if.master bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  // Limits and counters carry one extra bit so an all-ones register maps to 2^CNT_W beats.
  localparam logic [CNT_W:0] CntOne = {{CNT_W{1'b0}}, 1'b1};

  state_e           state_q;
  logic [CNT_W:0]   limit_q [N_OUT];
  logic [CNT_W:0]   cnt_q   [N_OUT];
  logic [CNT_W:0]   cnt_d   [N_OUT];
  logic [N_IN-1:0]  in_fin_q, in_fin_d;
  logic [N_OUT-1:0] out_fin_q, out_fin_d;
  logic [N_OUT-1:0] overrun_q, ovr_hit;
  logic [31:0]      cycles_q, cycles_inc;
  logic             busy_q, en_q, done_q;
  logic             all_ready, all_full, job_end;

  // Next-state helpers: done flags including this cycle's pulses, gated beat counts, exit test.
  always_comb begin
    all_ready  = (&bus.in_ready) & (&bus.out_ready);
    in_fin_d   = in_fin_q | bus.in_done;
    out_fin_d  = out_fin_q | bus.out_done;
    cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    all_full   = 1'b1;
    ovr_hit    = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt_d[k]   = cnt_q[k];
      ovr_hit[k] = bus.out_beat[k] && (cnt_q[k] == limit_q[k]);
      if (bus.out_beat[k] && (cnt_q[k] < limit_q[k])) begin
        cnt_d[k] = cnt_q[k] + CntOne;
      end
      if (cnt_d[k] != limit_q[k]) begin
        all_full = 1'b0;
      end
    end
    job_end = (&in_fin_d) & (&out_fin_d) & all_full;
  end

  // Job FSM with registered status outputs; reset and soft clear both return everything to idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clear) begin
      state_q   <= StIdle;
      in_fin_q  <= '0;
      out_fin_q <= '0;
      overrun_q <= '0;
      cycles_q  <= '0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        limit_q[k] <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int k = 0; k < N_OUT; k++) begin
              limit_q[k] <= {1'b0, bus.cnt_limit[k*CNT_W +: CNT_W]} + CntOne;
              cnt_q[k]   <= '0;
            end
            in_fin_q  <= '0;
            out_fin_q <= '0;
            overrun_q <= '0;
            cycles_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= StArm;
          end
        end
        StArm: begin
          // A streamer may finish a trivially short transfer before the engine is enabled.
          in_fin_q  <= in_fin_d;
          out_fin_q <= out_fin_d;
          cycles_q  <= cycles_inc;
          if (all_ready) begin
            en_q    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          in_fin_q  <= in_fin_d;
          out_fin_q <= out_fin_d;
          cycles_q  <= cycles_inc;
          overrun_q <= overrun_q | ovr_hit;
          for (int k = 0; k < N_OUT; k++) begin
            cnt_q[k] <= cnt_d[k];
          end
          if (job_end) begin
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Requests fire in the ARM cycle where every streamer is ready; they depend on the live readies.
  assign bus.in_req       = {N_IN{(state_q == StArm) && all_ready}};
  assign bus.out_req      = {N_OUT{(state_q == StArm) && all_ready}};
  assign bus.engine_clear = (state_q == StArm) && all_ready;
  assign bus.engine_en    = en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overrun      = overrun_q;
  assign bus.cycles       = cycles_q;

endmodule

// File: tb/tb_multi_dataflow_stream_sched.sv
// Directed bench for the stream scheduler: a job-level reference model is checked against the
// DUT every cycle, and literal checkpoints pin the model to hand-computed values.
module tb_multi_dataflow_stream_sched;
  localparam int unsigned NI = 2;
  localparam int unsigned NO = 2;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  bit   run_cmp = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multi_dataflow_stream_sched_if #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) bus ();

  multi_dataflow_stream_sched #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: job phase 0 idle, 1 arming, 2 running, 3 reporting done.
  int      phase = 0;
  int      lim [NO];
  int      cnt [NO];
  bit [NI-1:0] m_in_fin;
  bit [NO-1:0] m_out_fin;
  bit [NO-1:0] m_ovr;
  longint  m_cyc = 0;

  always @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      phase = 0; m_in_fin = '0; m_out_fin = '0; m_ovr = '0; m_cyc = 0;
      for (int k = 0; k < NO; k++) begin lim[k] = 0; cnt[k] = 0; end
    end else if (phase == 0) begin
      if (bus.start) begin
        for (int k = 0; k < NO; k++) begin
          lim[k] = int'(bus.cnt_limit[k*CW +: CW]) + 1;
          cnt[k] = 0;
        end
        m_in_fin = '0; m_out_fin = '0; m_ovr = '0; m_cyc = 0;
        phase = 1;
      end
    end else if (phase == 1 || phase == 2) begin
      bit finished;
      m_in_fin  = m_in_fin | bus.in_done;
      m_out_fin = m_out_fin | bus.out_done;
      if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (phase == 1) begin
        if ((&bus.in_ready) && (&bus.out_ready)) phase = 2;
      end else begin
        finished = (&m_in_fin) && (&m_out_fin);
        for (int k = 0; k < NO; k++) begin
          if (bus.out_beat[k]) begin
            if (cnt[k] < lim[k]) cnt[k] = cnt[k] + 1;
            else m_ovr[k] = 1'b1;
          end
          if (cnt[k] != lim[k]) finished = 1'b0;
        end
        if (finished) phase = 3;
      end
    end else begin
      phase = 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      bit req;
      req = (phase == 1) && (&bus.in_ready) && (&bus.out_ready);
      check("in_req", 32'(bus.in_req), req ? 32'(2'b11) : 32'd0);
      check("out_req", 32'(bus.out_req), req ? 32'(2'b11) : 32'd0);
      check("engine_clear", 32'(bus.engine_clear), 32'(req));
      check("engine_en", 32'(bus.engine_en), 32'(phase == 2));
      check("busy", 32'(bus.busy), 32'(phase != 0));
      check("done", 32'(bus.done), 32'(phase == 3));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
      check("cycles", bus.cycles, m_cyc[31:0]);
    end
  end

  // One clock of stimulus; pulses are dropped again right after the edge.
  task automatic cyc(input logic st, input logic [NI-1:0] ido, input logic [NO-1:0] odo,
                     input logic [NO-1:0] bt);
    bus.start = st; bus.in_done = ido; bus.out_done = odo; bus.out_beat = bt;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_done = '0; bus.out_done = '0; bus.out_beat = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.start = 1'b0; bus.cnt_limit = '0;
    bus.in_ready = '1; bus.out_ready = '1;
    bus.in_done = '0; bus.out_done = '0; bus.out_beat = '0;
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cycles", bus.cycles, 32'd0);
    check("rst_req", 32'({bus.in_req, bus.out_req, bus.engine_clear}), 32'd0);
    rst_n = 1'b1;

    // T1: sink0 8 beats, sink1 1 beat, readies high.
    bus.cnt_limit = {8'd0, 8'd7};
    cyc(1'b1, '0, '0, '0);
    check("t1_req", 32'({bus.in_req, bus.out_req, bus.engine_clear}), 32'b11111);
    check("t1_en_off", 32'(bus.engine_en), 32'd0);
    cyc(1'b0, '0, '0, '0);
    check("t1_en_on", 32'(bus.engine_en), 32'd1);
    cyc(1'b0, 2'b11, 2'b11, 2'b11);
    repeat (6) cyc(1'b0, '0, '0, 2'b01);
    check("t1_not_done", 32'(bus.done), 32'd0);
    cyc(1'b0, '0, '0, 2'b01);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_cycles", bus.cycles, 32'd9);
    cyc(1'b0, '0, '0, '0);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    check("t1_cycles_frozen", bus.cycles, 32'd9);

    // T2: sink ready low for five cycles holds ARM.
    bus.cnt_limit = {8'd0, 8'd1};
    bus.out_ready = 2'b10;
    cyc(1'b1, '0, '0, '0);
    repeat (5) begin
      check("t2_no_req", 32'({bus.in_req, bus.out_req, bus.engine_clear}), 32'd0);
      cyc(1'b0, '0, '0, '0);
    end
    check("t2_armed_busy", 32'({bus.busy, bus.engine_en}), 32'b10);
    bus.out_ready = 2'b11;
    #1;
    check("t2_req", 32'({bus.in_req, bus.out_req, bus.engine_clear}), 32'b11111);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, 2'b11, 2'b11, 2'b11);
    cyc(1'b0, '0, '0, 2'b01);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_cycles", bus.cycles, 32'd8);
    cyc(1'b0, '0, '0, '0);

    // T3: limit 4 beats, 6 delivered.
    bus.cnt_limit = {8'd0, 8'd3};
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, '0, '0, 2'b11);
    repeat (3) cyc(1'b0, '0, '0, 2'b01);
    check("t3_no_ovr", 32'(bus.overrun), 32'd0);
    cyc(1'b0, '0, '0, 2'b01);
    check("t3_ovr", 32'(bus.overrun), 32'b01);
    cyc(1'b0, '0, '0, 2'b01);
    cyc(1'b0, 2'b11, 2'b11, '0);
    check("t3_done", 32'(bus.done), 32'd1);
    cyc(1'b0, '0, '0, '0);
    check("t3_ovr_sticky", 32'(bus.overrun), 32'b01);

    // T4: limits 1 and 16, early done on sink0, final beat and done together on sink1.
    bus.cnt_limit = {8'd15, 8'd0};
    cyc(1'b1, '0, '0, '0);
    check("t4_ovr_cleared", 32'(bus.overrun), 32'd0);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, 2'b11, 2'b01, 2'b01);
    repeat (15) cyc(1'b0, '0, '0, 2'b10);
    check("t4_wait", 32'({bus.done, bus.busy}), 32'b01);
    cyc(1'b0, '0, 2'b10, 2'b10);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_cycles", bus.cycles, 32'd18);
    cyc(1'b0, '0, '0, '0);

    // T5: soft clear mid-run, then a clean job.
    bus.cnt_limit = {8'd0, 8'd7};
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    repeat (5) cyc(1'b0, '0, '0, 2'b01);
    bus.clear = 1'b1;
    cyc(1'b0, 2'b11, 2'b11, 2'b01);
    bus.clear = 1'b0;
    check("t5_clear", 32'({bus.busy, bus.engine_en, bus.done, bus.overrun}), 32'd0);
    check("t5_clear_cycles", bus.cycles, 32'd0);
    bus.cnt_limit = {8'd0, 8'd0};
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, 2'b11, 2'b11, 2'b11);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_cycles", bus.cycles, 32'd2);
    cyc(1'b0, '0, '0, '0);

    // T6: starts during RUN are ignored; reset mid-job.
    bus.cnt_limit = {8'd0, 8'd3};
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b1, '0, '0, 2'b01);
    cyc(1'b1, '0, '0, 2'b01);
    check("t6_busy", 32'(bus.busy), 32'd1);
    check("t6_cycles", bus.cycles, 32'd3);
    rst_n = 1'b0;
    cyc(1'b0, '0, '0, 2'b01);
    rst_n = 1'b1;
    check("t6_reset", 32'({bus.busy, bus.engine_en, bus.done, bus.overrun}), 32'd0);
    check("t6_reset_cycles", bus.cycles, 32'd0);

    // T7: all-ones limit register means 256 beats.
    bus.cnt_limit = {8'd0, 8'd255};
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, 2'b11, 2'b11, 2'b11);
    repeat (254) cyc(1'b0, '0, '0, 2'b01);
    check("t7_wait", 32'(bus.done), 32'd0);
    cyc(1'b0, '0, '0, 2'b01);
    check("t7_done", 32'({bus.done, bus.overrun}), 32'b100);
    cyc(1'b0, '0, '0, '0);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
